// File: rtl/econ_pkg.sv
// Shared economy types, base asset tables and saturating-arithmetic helper.
package econ_pkg;

  localparam int unsigned CLICK_COST_INIT = 10;

  typedef enum logic {
    IDLE = 1'b0,
    BULK = 1'b1
  } state_e;

  function automatic logic [63:0] base_cost(input logic [2:0] idx);
    case (idx)
      3'd0:    base_cost = 64'd10;
      3'd1:    base_cost = 64'd40;
      3'd2:    base_cost = 64'd250;
      3'd3:    base_cost = 64'd2000;
      3'd4:    base_cost = 64'd10000;
      3'd5:    base_cost = 64'd100000;
      3'd6:    base_cost = 64'd1000000;
      default: base_cost = 64'd10000000;
    endcase
  endfunction

  function automatic logic [63:0] base_rate(input logic [2:0] idx);
    case (idx)
      3'd0:    base_rate = 64'd1;
      3'd1:    base_rate = 64'd5;
      3'd2:    base_rate = 64'd15;
      3'd3:    base_rate = 64'd60;
      3'd4:    base_rate = 64'd800;
      3'd5:    base_rate = 64'd10000;
      3'd6:    base_rate = 64'd50000;
      default: base_rate = 64'd500000;
    endcase
  endfunction

  // a + b clamped to the all-ones value of a w-bit register
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'(1) << w) - 65'(1);
    if (sum > lim) sat_add = lim[63:0];
    else           sat_add = sum[63:0];
  endfunction

endpackage

// File: rtl/economy_datapath_p_asset_bank.sv
// Per-asset cost and owned-count register file with escalating cost on purchase.
module asset_bank
  import econ_pkg::*;
#(
  parameter int unsigned NUM_ASSETS = 8,
  parameter int unsigned COST_W     = 32,
  parameter int unsigned COUNT_W    = 8,
  parameter int unsigned COST_SHIFT = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [2:0]         idx,
  output logic [COST_W-1:0]  cost,
  output logic [COUNT_W-1:0] count
);

  logic [COST_W-1:0]  cost_q  [NUM_ASSETS];
  logic [COST_W-1:0]  cost_d  [NUM_ASSETS];
  logic [COUNT_W-1:0] count_q [NUM_ASSETS];
  logic [COUNT_W-1:0] count_d [NUM_ASSETS];

  always_comb begin
    cost_d  = cost_q;
    count_d = count_q;
    if (wr_en) begin
      cost_d[idx]  = COST_W'(sat_add(sat_add(64'(cost_q[idx]), 64'(cost_q[idx] >> COST_SHIFT), COST_W),
                                     64'd1, COST_W));
      count_d[idx] = COUNT_W'(sat_add(64'(count_q[idx]), 64'd1, COUNT_W));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_ASSETS; i++) begin
        cost_q[i]  <= COST_W'(base_cost(3'(i)));
        count_q[i] <= '0;
      end
    end else begin
      cost_q  <= cost_d;
      count_q <= count_d;
    end
  end

  assign cost  = cost_q[idx];
  assign count = count_q[idx];

endmodule

// File: rtl/economy_datapath_p.sv
// Game economy datapath: money, income, click yield, asset purchases and bulk buy FSM.
module economy_datapath_p
  import econ_pkg::*;
#(
  parameter int unsigned NUM_ASSETS  = 8,
  parameter int unsigned MONEY_W     = 40,
  parameter int unsigned RATE_W      = 30,
  parameter int unsigned COST_W      = 32,
  parameter int unsigned COUNT_W     = 8,
  parameter int unsigned START_MONEY = 10,
  parameter int unsigned COST_SHIFT  = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               key_release,
  input  logic               pulse,
  input  logic               click,
  input  logic               buy,
  input  logic               buy_max,
  input  logic               cancel,
  input  logic               upgrade_click,
  input  logic               select_valid,
  input  logic [2:0]         select_idx,
  output logic [MONEY_W-1:0] money,
  output logic [RATE_W-1:0]  rate,
  output logic [RATE_W-1:0]  click_rate,
  output logic [2:0]         selected_asset,
  output logic [COST_W-1:0]  selected_cost,
  output logic [COUNT_W-1:0] selected_count,
  output logic               busy,
  output logic               bought
);

  logic [MONEY_W-1:0] money_q, money_d;
  logic [RATE_W-1:0]  rate_q, rate_d;
  logic [RATE_W-1:0]  click_rate_q, click_rate_d;
  logic [COST_W-1:0]  click_cost_q, click_cost_d;
  logic [2:0]         sel_q, sel_d;
  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               bought_q, bought_d;

  logic               commit;
  logic               upg;
  logic               afford;
  logic [63:0]        spend;
  logic [63:0]        add;
  logic [COST_W-1:0]  bank_cost;
  logic [COUNT_W-1:0] bank_count;

  asset_bank #(
    .NUM_ASSETS (NUM_ASSETS),
    .COST_W     (COST_W),
    .COUNT_W    (COUNT_W),
    .COST_SHIFT (COST_SHIFT)
  ) u_bank (
    .clock (clock),
    .reset (reset),
    .wr_en (commit),
    .idx   (sel_q),
    .cost  (bank_cost),
    .count (bank_count)
  );

  always_comb begin
    money_d      = money_q;
    rate_d       = rate_q;
    click_rate_d = click_rate_q;
    click_cost_d = click_cost_q;
    sel_d        = sel_q;
    state_d      = state_q;
    busy_d       = busy_q;
    bought_d     = 1'b0;
    commit       = 1'b0;
    upg          = 1'b0;
    spend        = 64'd0;
    add          = 64'd0;
    afford       = (64'(money_q) >= 64'(bank_cost)) && (bank_count != '1);

    if (!key_release) begin
      case (state_q)
        IDLE: begin
          if (buy) begin
            commit = afford;
          end else if (buy_max) begin
            if (afford) begin
              commit  = 1'b1;
              state_d = BULK;
            end
          end else if (upgrade_click && (64'(money_q) >= 64'(click_cost_q))) begin
            upg = 1'b1;
          end
          if (select_valid && (32'(select_idx) < NUM_ASSETS)) sel_d = select_idx;
        end
        BULK: begin
          if (afford && !cancel) commit = 1'b1;
          else                   state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      // Spend first, then income; afford guarantees the difference is non-negative
      if (commit)   spend = 64'(bank_cost);
      else if (upg) spend = 64'(click_cost_q);
      add     = (click ? 64'(click_rate_q) : 64'd0) + (pulse ? 64'(rate_q) : 64'd0);
      money_d = MONEY_W'(sat_add(64'(money_q) - spend, add, MONEY_W));

      if (commit) begin
        rate_d   = RATE_W'(sat_add(64'(rate_q), base_rate(sel_q), RATE_W));
        bought_d = 1'b1;
      end
      if (upg) begin
        click_rate_d = RATE_W'(sat_add(64'(click_rate_q), 64'(click_rate_q), RATE_W));
        click_cost_d = COST_W'(sat_add(64'(click_cost_q), 64'(click_cost_q), COST_W));
      end
      busy_d = (state_d == BULK);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      money_q      <= MONEY_W'(START_MONEY);
      rate_q       <= '0;
      click_rate_q <= RATE_W'(1);
      click_cost_q <= COST_W'(CLICK_COST_INIT);
      sel_q        <= '0;
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      bought_q     <= 1'b0;
    end else begin
      money_q      <= money_d;
      rate_q       <= rate_d;
      click_rate_q <= click_rate_d;
      click_cost_q <= click_cost_d;
      sel_q        <= sel_d;
      state_q      <= state_d;
      busy_q       <= busy_d;
      bought_q     <= bought_d;
    end
  end

  assign money          = money_q;
  assign rate           = rate_q;
  assign click_rate     = click_rate_q;
  assign selected_asset = sel_q;
  assign selected_cost  = bank_cost;
  assign selected_count = bank_count;
  assign busy           = busy_q;
  assign bought         = bought_q;

endmodule

// File: tb/tb_economy_datapath_p.sv
// Directed self-checking bench for economy_datapath_p, plus a narrow-money instance for saturation.
module tb_economy_datapath_p;

  logic        clock;
  logic        reset;
  logic        key_release, pulse, click, buy, buy_max, cancel, upgrade_click, select_valid;
  logic [2:0]  select_idx;

  logic [39:0] money;
  logic [29:0] rate, click_rate;
  logic [2:0]  selected_asset;
  logic [31:0] selected_cost;
  logic [7:0]  selected_count;
  logic        busy, bought;

  logic [7:0]  s_money;
  logic [29:0] s_rate, s_click_rate;
  logic [2:0]  s_selected_asset;
  logic [31:0] s_selected_cost;
  logic [7:0]  s_selected_count;
  logic        s_busy, s_bought;

  int total = 0;
  int bad   = 0;

  economy_datapath_p dut (
    .clock(clock), .reset(reset), .key_release(key_release), .pulse(pulse), .click(click),
    .buy(buy), .buy_max(buy_max), .cancel(cancel), .upgrade_click(upgrade_click),
    .select_valid(select_valid), .select_idx(select_idx),
    .money(money), .rate(rate), .click_rate(click_rate), .selected_asset(selected_asset),
    .selected_cost(selected_cost), .selected_count(selected_count), .busy(busy), .bought(bought)
  );

  economy_datapath_p #(.MONEY_W(8), .START_MONEY(252)) u_sat (
    .clock(clock), .reset(reset), .key_release(key_release), .pulse(pulse), .click(click),
    .buy(buy), .buy_max(buy_max), .cancel(cancel), .upgrade_click(upgrade_click),
    .select_valid(select_valid), .select_idx(select_idx),
    .money(s_money), .rate(s_rate), .click_rate(s_click_rate), .selected_asset(s_selected_asset),
    .selected_cost(s_selected_cost), .selected_count(s_selected_count), .busy(s_busy),
    .bought(s_bought)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    key_release = 0; pulse = 0; click = 0; buy = 0; buy_max = 0; cancel = 0;
    upgrade_click = 0; select_valid = 0; select_idx = 3'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // reset, then click 30 times at click_rate 1 to reach money 40
  task automatic reset_to_40();
    do_reset();
    click = 1'b1;
    repeat (30) step();
    click = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_money", 64'(money), 64'd10);
    chk("rst_rate", 64'(rate), 64'd0);
    chk("rst_click_rate", 64'(click_rate), 64'd1);
    chk("rst_sel_cost", 64'(selected_cost), 64'd10);
    chk("rst_sel_count", 64'(selected_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_bought", 64'(bought), 64'd0);
    chk("rst_sel", 64'(selected_asset), 64'd0);
    chk("rst_s_rate", 64'(s_rate), 64'd0);
    chk("rst_s_cr", 64'(s_click_rate), 64'd1);
    chk("rst_s_sel", 64'(s_selected_asset), 64'd0);
    chk("rst_s_cost", 64'(s_selected_cost), 64'd10);
    chk("rst_s_count", 64'(s_selected_count), 64'd0);
    chk("rst_s_busy", 64'(s_busy), 64'd0);
    chk("rst_s_bought", 64'(s_bought), 64'd0);

    // single buy of asset 0
    buy = 1'b1;
    step();
    buy = 1'b0;
    chk("buy_money", 64'(money), 64'd0);
    chk("buy_rate", 64'(rate), 64'd1);
    chk("buy_count", 64'(selected_count), 64'd1);
    chk("buy_cost", 64'(selected_cost), 64'd12);
    chk("buy_bought", 64'(bought), 64'd1);
    step();
    chk("buy_bought_clr", 64'(bought), 64'd0);

    // click + pulse with an unaffordable buy in the same cycle
    click = 1'b1; pulse = 1'b1; buy = 1'b1;
    step();
    idle_inputs();
    chk("inc_money", 64'(money), 64'd2);
    chk("inc_count", 64'(selected_count), 64'd1);
    chk("inc_bought", 64'(bought), 64'd0);

    // selection
    select_valid = 1'b1; select_idx = 3'd1;
    step();
    chk("sel1_idx", 64'(selected_asset), 64'd1);
    chk("sel1_cost", 64'(selected_cost), 64'd40);
    chk("sel1_count", 64'(selected_count), 64'd0);
    select_idx = 3'd0;
    step();
    select_valid = 1'b0;
    chk("sel0_cost", 64'(selected_cost), 64'd12);

    // click upgrades: cost 10, then 20
    do_reset();
    upgrade_click = 1'b1;
    step();
    chk("upg1_money", 64'(money), 64'd0);
    chk("upg1_cr", 64'(click_rate), 64'd2);
    step();
    upgrade_click = 1'b0;
    chk("upg_drop_cr", 64'(click_rate), 64'd2);
    click = 1'b1;
    repeat (9) step();
    click = 1'b0;
    chk("clicks_money", 64'(money), 64'd18);
    upgrade_click = 1'b1;
    step();
    upgrade_click = 1'b0;
    chk("upg_18_money", 64'(money), 64'd18);
    chk("upg_18_cr", 64'(click_rate), 64'd2);
    click = 1'b1;
    step();
    click = 1'b0;
    upgrade_click = 1'b1;
    step();
    upgrade_click = 1'b0;
    chk("upg2_money", 64'(money), 64'd0);
    chk("upg2_cr", 64'(click_rate), 64'd4);

    // bulk buy from money 40: purchases at 10, 12, 14 then exit
    reset_to_40();
    chk("m40", 64'(money), 64'd40);
    buy_max = 1'b1;
    step();
    buy_max = 1'b0;
    chk("bulk0_money", 64'(money), 64'd30);
    chk("bulk0_busy", 64'(busy), 64'd1);
    chk("bulk0_bought", 64'(bought), 64'd1);
    select_valid = 1'b1; select_idx = 3'd2;
    step();
    select_valid = 1'b0;
    chk("bulk1_money", 64'(money), 64'd18);
    chk("bulk1_cost", 64'(selected_cost), 64'd14);
    chk("bulk1_sel_locked", 64'(selected_asset), 64'd0);
    chk("bulk1_busy", 64'(busy), 64'd1);
    step();
    chk("bulk2_money", 64'(money), 64'd4);
    chk("bulk2_rate", 64'(rate), 64'd3);
    chk("bulk2_count", 64'(selected_count), 64'd3);
    chk("bulk2_cost", 64'(selected_cost), 64'd16);
    chk("bulk2_busy", 64'(busy), 64'd1);
    chk("bulk2_bought", 64'(bought), 64'd1);
    step();
    chk("bulk3_money", 64'(money), 64'd4);
    chk("bulk3_busy", 64'(busy), 64'd0);
    chk("bulk3_bought", 64'(bought), 64'd0);

    // bulk buy cancelled after the first purchase
    reset_to_40();
    buy_max = 1'b1;
    step();
    buy_max = 1'b0;
    cancel = 1'b1;
    chk("cxl0_busy", 64'(busy), 64'd1);
    step();
    cancel = 1'b0;
    chk("cxl_money", 64'(money), 64'd30);
    chk("cxl_count", 64'(selected_count), 64'd1);
    chk("cxl_busy", 64'(busy), 64'd0);
    chk("cxl_bought", 64'(bought), 64'd0);

    // key_release freezes everything
    key_release = 1'b1; click = 1'b1; pulse = 1'b1; buy = 1'b1; upgrade_click = 1'b1;
    select_valid = 1'b1; select_idx = 3'd3;
    step();
    step();
    idle_inputs();
    chk("kr_money", 64'(money), 64'd30);
    chk("kr_rate", 64'(rate), 64'd1);
    chk("kr_count", 64'(selected_count), 64'd1);
    chk("kr_cr", 64'(click_rate), 64'd1);
    chk("kr_sel", 64'(selected_asset), 64'd0);
    chk("kr_bought", 64'(bought), 64'd0);
    click = 1'b1; pulse = 1'b1;
    step();
    idle_inputs();
    chk("kr_resume_money", 64'(money), 64'd32);

    // reset in the middle of a bulk purchase
    reset_to_40();
    buy_max = 1'b1;
    step();
    buy_max = 1'b0;
    step();
    chk("midbulk_busy", 64'(busy), 64'd1);
    do_reset();
    chk("midrst_money", 64'(money), 64'd10);
    chk("midrst_rate", 64'(rate), 64'd0);
    chk("midrst_cr", 64'(click_rate), 64'd1);
    chk("midrst_cost", 64'(selected_cost), 64'd10);
    chk("midrst_count", 64'(selected_count), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_bought", 64'(bought), 64'd0);

    // saturation on the 8-bit money instance: 252 -> 242 -> 222, +4 x8 = 254, then clamp at 255
    chk("sat_start", 64'(s_money), 64'd252);
    upgrade_click = 1'b1;
    step();
    step();
    upgrade_click = 1'b0;
    chk("sat_upg_money", 64'(s_money), 64'd222);
    chk("sat_upg_cr", 64'(s_click_rate), 64'd4);
    click = 1'b1;
    repeat (8) step();
    chk("sat_254", 64'(s_money), 64'd254);
    step();
    chk("sat_255", 64'(s_money), 64'd255);
    step();
    click = 1'b0;
    chk("sat_hold", 64'(s_money), 64'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
